// File: rtl/multiword_add_seq.sv
// Sequential multiword adder/subtractor: one N-bit word per cycle
// through an external ripple-carry adder, LSW first.
module multiword_add_seq #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sub,
   input  logic               cin,
   input  logic [N*WORDS-1:0] A_in,
   input  logic [N*WORDS-1:0] B_in,
   output logic               busy,
   output logic               done,
   output logic [N*WORDS-1:0] result,
   output logic               cout,
   output logic               overflow,
   output logic [N-1:0]       adder_a,
   output logic [N-1:0]       adder_b,
   output logic               adder_cin,
   input  logic [N-1:0]       adder_sum,
   input  logic               adder_cout
);

   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, res_q;
   logic            sub_q, carry_q, cout_q, ovf_q;
   logic [IW-1:0]   idx_q;
   logic [N-1:0]    aw, bw;
   logic            run, last;

   assign run  = (state_q == RUN);
   assign last = (idx_q == IW'(WORDS - 1));

   // Current word of each operand; B is inverted for subtraction.
   always_comb begin
      aw = '0;
      bw = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IW'(w)) begin
            aw = a_q[w*N +: N];
            bw = b_q[w*N +: N];
         end
      end
      if (sub_q) bw = ~bw;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == IDLE && start) begin
         a_q     <= A_in;
         b_q     <= B_in;
         sub_q   <= sub;
         carry_q <= sub ? 1'b1 : cin;
         idx_q   <= '0;
      end else if (run) begin
         for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) res_q[w*N +: N] <= adder_sum;
         end
         carry_q <= adder_cout;
         if (last) begin
            cout_q <= adder_cout;
            ovf_q  <= (aw[N-1] == bw[N-1]) &&
                      (adder_sum[N-1] != aw[N-1]);
         end else begin
            idx_q <= idx_q + IW'(1);
         end
      end
   end

   assign adder_a   = run ? aw : '0;
   assign adder_b   = run ? bw : '0;
   assign adder_cin = run & carry_q;

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = res_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (N=8, WORDS=4) with an
// 8-bit ripple adder model on the adder ports.
module tb_multiword_add_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [31:0] A_in = '0;
   logic [31:0] B_in = '0;
   logic        busy, done, cout, overflow;
   logic [31:0] result;
   logic [7:0]  adder_a, adder_b, adder_sum;
   logic        adder_cin, adder_cout;
   logic [8:0]  s9;

   int checks = 0;
   int errors = 0;
   logic [3:0] cins;
   logic [7:0] b0;
   int lat;
   int npulse;

   multiword_add_seq #(.N(8), .WORDS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .A_in(A_in), .B_in(B_in), .busy(busy), .done(done),
      .result(result), .cout(cout), .overflow(overflow),
      .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
      .adder_sum(adder_sum), .adder_cout(adder_cout)
   );

   assign s9 = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};
   assign adder_sum  = s9[7:0];
   assign adder_cout = s9[8];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Cycle 1 is the one that begins at the accepting edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c);
      @(negedge clk);
      A_in = a; B_in = b; sub = s; cin = c; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      cins = '0;
      b0 = '0;
      for (int k = 1; k <= 20; k++) begin
         if (k <= 4) cins[k-1] = adder_cin;
         if (k == 1) b0 = adder_b;
         if (done) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #2;
      check("rst_result", result, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_adder_a", {24'd0, adder_a}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      check("t1_latency", lat, 5);
      check("t1_result", result, 32'h00000100);
      check("t1_cout", {31'd0, cout}, 32'd0);
      check("t1_ovf", {31'd0, overflow}, 32'd0);
      check("t1_busy_done", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("t1_done_1cyc", {31'd0, done}, 32'd0);
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
      check("idle_adder", {15'd0, adder_cin, adder_a, adder_b}, 32'd0);
      check("t1_hold", result, 32'h00000100);

      run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
      check("t2_result", result, 32'h00000000);
      check("t2_cout", {31'd0, cout}, 32'd1);
      check("t2_ovf", {31'd0, overflow}, 32'd0);
      check("t2_cin_ripple", {28'd0, cins}, 32'hF);

      run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0);
      check("t3_result", result, 32'hFFFFFFFE);
      check("t3_cout", {31'd0, cout}, 32'd0);
      check("t3_ovf", {31'd0, overflow}, 32'd0);
      check("t3_adder_b0", {24'd0, b0}, 32'h000000F8);
      check("t3_cin_first", {31'd0, cins[0]}, 32'd1);

      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      check("t4_result", result, 32'h80000000);
      check("t4_ovf", {31'd0, overflow}, 32'd1);
      check("t4_cout", {31'd0, cout}, 32'd0);

      run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1);
      check("t5_result", result, 32'h00000002);
      check("t5_cout", {31'd0, cout}, 32'd1);

      run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
      check("t6_result", result, 32'h7FFFFFFF);
      check("t6_ovf", {31'd0, overflow}, 32'd1);
      check("t6_cout", {31'd0, cout}, 32'd1);

      // start held high through RUN and DONE with junk operands
      @(negedge clk);
      A_in = 32'h12345678; B_in = 32'h11111111;
      sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      npulse = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done) npulse++;
         if (k == 5) check("t7_result", result, 32'h23456789);
         if (k == 6) begin
            check("t7_busy_after", {31'd0, busy}, 32'd0);
            check("t7_hold", result, 32'h23456789);
         end
         if (k <= 5) begin
            A_in = 32'hFFFFFFFF; B_in = 32'hFFFFFFFF;
            sub = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      check("t7_one_done", npulse, 1);
      check("t7_final", result, 32'h23456789);

      run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0);
      check("t8_result", result, 32'h00000003);
      check("t8_latency", lat, 5);

      // asynchronous reset in the second RUN cycle
      @(negedge clk);
      A_in = 32'hAAAAAAAA; B_in = 32'h11111111;
      sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t9_rst_busy", {31'd0, busy}, 32'd0);
      check("t9_rst_done", {31'd0, done}, 32'd0);
      check("t9_rst_result", result, 32'h0);
      check("t9_rst_flags", {30'd0, cout, overflow}, 32'd0);
      check("t9_rst_adder", {15'd0, adder_cin, adder_a, adder_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      npulse = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done || busy) npulse++;
      end
      check("t9_no_done", npulse, 0);

      run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0);
      check("t10_result", result, 32'h11223344);
      check("t10_latency", lat, 5);
      check("t10_cout", {31'd0, cout}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
